// File: rtl/silly_function_pkg.sv
// rtl/silly_function_pkg.sv - shared truth table constant and reference evaluators for silly_function
package silly_function_pkg;

  // Bit i holds y for input index i = {a,b,c}; minterms 001,010,011,110,111.
  localparam logic [7:0] SILLY_TT = 8'hCE;

  // Sum-of-products form of the default function: y = b | (~a & c).
  function automatic logic silly_eval(logic [2:0] abc);
    return abc[1] | (~abc[2] & abc[0]);
  endfunction

  // True when every entry of a truth table matches the sum-of-products form.
  function automatic logic tt_matches_sop(logic [7:0] tt);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tt[i] != silly_eval(3'(i))) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/silly_function.sv
// rtl/silly_function.sv - 3-input table-driven Boolean function with combinational and registered outputs
module silly_function
  import silly_function_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = SILLY_TT,
  parameter logic       RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y,
  output logic y_q
);

  logic [2:0] abc;

  assign abc = {a, b, c};

  // Table lookup; an X/Z on any input propagates to y rather than being masked.
  assign y = TRUTH_TABLE[abc];

  // The lookup and the SOP form must describe the same function when the default table is used.
  if (TRUTH_TABLE == SILLY_TT) begin : g_default_tt_check
    if (!tt_matches_sop(TRUTH_TABLE)) begin : g_tt_mismatch
      $error("silly_function: default truth table disagrees with b | (~a & c)");
    end
  end

  // Registered copy of y; reset forces RESET_VAL immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= RESET_VAL;
    end else begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_silly_function.sv
// tb/tb_silly_function.sv - self-checking bench for silly_function (default table and AND3 override)
module tb_silly_function;

  logic clk;
  logic reset;
  logic a, b, c;
  logic y, y_q;
  logic y_and, y_q_and;

  int tests;
  int fails;

  // Minterm lists describing each function at the set level.
  int default_minterms[$] = '{1, 2, 3, 6, 7};
  int and3_minterms[$]    = '{7};

  silly_function dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .y_q   (y_q)
  );

  silly_function #(.TRUTH_TABLE(8'h80)) dut_and3 (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y_and),
    .y_q   (y_q_and)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_set(int idx, int set[$]);
    foreach (set[k]) if (set[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ref_default(int idx);
    return in_set(idx, default_minterms);
  endfunction

  function automatic logic ref_and3(int idx);
    return in_set(idx, and3_minterms);
  endfunction

  task automatic check(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, observed, expected);
    end
  endtask

  task automatic drive(input int idx);
    a = idx[2];
    b = idx[1];
    c = idx[0];
  endtask

  initial begin
    int idx;
    logic exp_q;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive(0);

    // Exhaustive combinational sweep with reset held high.
    for (int i = 0; i < 8; i++) begin
      drive(i);
      #1;
      check($sformatf("sweep_y_%0d", i), y, ref_default(i));
      check($sformatf("sweep_and3_%0d", i), y_and, ref_and3(i));
      check($sformatf("sweep_yq_reset_%0d", i), y_q, 1'b0);
      #9;
    end

    // Reset with abc=111: y already 1, y_q held at reset value.
    @(negedge clk);
    drive(7);
    #1;
    check("reset_y", y, 1'b1);
    check("reset_yq", y_q, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_yq", y_q, 1'b1);
    check("post_reset_and3_yq", y_q_and, 1'b1);

    // Asynchronous reset between edges while y_q is 1.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_yq", y_q, 1'b0);
    check("async_reset_clk_low", clk, 1'b0);
    reset = 1'b0;

    // Latency: 000 -> 010 right after an edge.
    drive(0);
    @(posedge clk);
    #1;
    check("lat_pre_yq", y_q, 1'b0);
    drive(2);
    #1;
    check("lat_y_now", y, 1'b1);
    check("lat_yq_old", y_q, 1'b0);
    @(posedge clk);
    #1;
    check("lat_yq_new", y_q, 1'b1);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      idx = int'($urandom_range(0, 7));
      drive(idx);
      #1;
      check("rand_y", y, ref_default(idx));
      check("rand_and3", y_and, ref_and3(idx));
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_async_reset", y_q, 1'b0);
        check("rand_async_reset_and3", y_q_and, 1'b0);
        reset = 1'b0;
      end
      exp_q = ref_default(idx);
      @(posedge clk);
      #1;
      check("rand_yq", y_q, exp_q);
      check("rand_yq_and3", y_q_and, ref_and3(idx));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
